// File: rtl/ipsxe_floating_point_lzd_sched64.sv
// Time-shares one external 16-bit leading-one detector across a 64-bit operand:
// issues four slices MSB-first, collects results in order, reports position/lz/zero.
module ipsxe_floating_point_lzd_sched64 #(
    parameter int unsigned DET_LAT = 2,
    parameter int unsigned TAG_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_aclken,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [63:0]      i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic [15:0]      o_det_data,
    input  logic [3:0]       i_det_loc,
    input  logic             i_det_zero,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [5:0]       o_pos,
    output logic [6:0]       o_lz,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [63:0]        data_q, data_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [1:0]         k_q, k_d;
    logic [1:0]         j_q, j_d;
    logic               found_q, found_d;
    logic [5:0]         pos_q, pos_d;
    logic [DET_LAT-1:0] vld_q, vld_d;
    logic               sample;

    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic [15:0]        det_q, det_d;
    logic [5:0]         opos_q, opos_d;
    logic [6:0]         olz_q, olz_d;
    logic               ozero_q, ozero_d;
    logic [TAG_W-1:0]   otag_q, otag_d;

    function automatic logic [15:0] slice_of(input logic [63:0] d, input logic [1:0] idx);
        case (idx)
            2'd0:    return d[63:48];
            2'd1:    return d[47:32];
            2'd2:    return d[31:16];
            default: return d[15:0];
        endcase
    endfunction

    // vld_q marks which past cycles issued a slice; its top bit means a result is due now
    assign sample = vld_q[DET_LAT-1];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        k_d     = k_q;
        j_d     = j_q;
        found_d = found_q;
        pos_d   = pos_q;
        vld_d   = (vld_q << 1) | DET_LAT'(state_q == S_ISSUE);
        det_d   = 16'h0;
        opos_d  = opos_q;
        olz_d   = olz_q;
        ozero_d = ozero_q;
        otag_d  = otag_q;

        if (sample) begin
            j_d = j_q + 2'd1;
            if (!found_q && !i_det_zero) begin
                found_d = 1'b1;
                pos_d   = {2'(2'd3 - j_q), i_det_loc};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    tag_d   = i_tag;
                    k_d     = 2'd0;
                    j_d     = 2'd0;
                    found_d = 1'b0;
                    det_d   = i_data[63:48];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_DRAIN;
                end else begin
                    det_d = slice_of(data_q, k_q + 2'd1);
                end
            end
            S_DRAIN: begin
                // found_d/pos_d already include this cycle's final sample
                if (sample && j_q == 2'd3) begin
                    state_d = S_DONE;
                    otag_d  = tag_q;
                    if (found_d) begin
                        opos_d  = pos_d;
                        olz_d   = 7'd63 - {1'b0, pos_d};
                        ozero_d = 1'b0;
                    end else begin
                        opos_d  = 6'd0;
                        olz_d   = 7'd64;
                        ozero_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            data_q  <= 64'h0;
            tag_q   <= '0;
            k_q     <= 2'd0;
            j_q     <= 2'd0;
            found_q <= 1'b0;
            pos_q   <= 6'd0;
            vld_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            det_q   <= 16'h0;
            opos_q  <= 6'd0;
            olz_q   <= 7'd0;
            ozero_q <= 1'b0;
            otag_q  <= '0;
        end else if (i_aclken) begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            k_q     <= k_d;
            j_q     <= j_d;
            found_q <= found_d;
            pos_q   <= pos_d;
            vld_q   <= vld_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            det_q   <= det_d;
            opos_q  <= opos_d;
            olz_q   <= olz_d;
            ozero_q <= ozero_d;
            otag_q  <= otag_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_det_data = det_q;
    assign o_pos      = opos_q;
    assign o_lz       = olz_q;
    assign o_zero     = ozero_q;
    assign o_tag      = otag_q;

endmodule

// File: tb/tb_ipsxe_floating_point_lzd_sched64.sv
// Bench for the leading-one detector sequencer: external detector model,
// table vectors, randomized operands against a 64-bit reference, corner sequences.
module tb_ipsxe_floating_point_lzd_sched64;

    localparam int unsigned DET_LAT = 2;
    localparam int unsigned TAG_W   = 8;
    localparam int unsigned LAT     = 5 + DET_LAT;

    logic             i_clk, i_rst, i_aclken, i_valid, o_ready;
    logic [63:0]      i_data;
    logic [TAG_W-1:0] i_tag;
    logic [15:0]      o_det_data;
    logic [3:0]       i_det_loc;
    logic             i_det_zero;
    logic             o_valid, i_ready;
    logic [5:0]       o_pos;
    logic [6:0]       o_lz;
    logic             o_zero;
    logic [TAG_W-1:0] o_tag;

    int checks = 0;
    int errors = 0;

    ipsxe_floating_point_lzd_sched64 #(.DET_LAT(DET_LAT), .TAG_W(TAG_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_aclken(i_aclken), .i_valid(i_valid),
        .o_ready(o_ready), .i_data(i_data), .i_tag(i_tag), .o_det_data(o_det_data),
        .i_det_loc(i_det_loc), .i_det_zero(i_det_zero), .o_valid(o_valid),
        .i_ready(i_ready), .o_pos(o_pos), .o_lz(o_lz), .o_zero(o_zero), .o_tag(o_tag)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // External detector: DET_LAT enabled-cycle pipeline, no reset
    logic [15:0] det_pipe [DET_LAT];
    always @(posedge i_clk) begin
        if (i_aclken) begin
            det_pipe[0] <= o_det_data;
            for (int s = 1; s < int'(DET_LAT); s++) det_pipe[s] <= det_pipe[s-1];
        end
    end

    function automatic logic [3:0] loc16(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int b = 0; b < 16; b++) if (v[b]) r = 4'(b);
        return r;
    endfunction

    assign i_det_loc  = loc16(det_pipe[DET_LAT-1]);
    assign i_det_zero = (det_pipe[DET_LAT-1] == 16'h0);

    // Reference: highest set bit of the whole 64-bit operand
    function automatic int ref_pos(input logic [63:0] v);
        int r;
        r = -1;
        for (int b = 0; b < 64; b++) if (v[b]) r = b;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Accept one operand, wait for its result, check it, optionally stall i_ready
    task automatic run_op(input logic [63:0] d, input logic [TAG_W-1:0] t, input int stall,
                          input logic [5:0] ep, input logic [6:0] el, input logic ez);
        int n;
        n = 0;
        while (!o_ready && n < 40) begin step(); n++; end
        check("ready_before_op", 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_data = d; i_tag = t;
        i_ready = (stall == 0);
        step();
        i_valid = 1'b0; i_data = {$urandom, $urandom}; i_tag = TAG_W'($urandom);
        check("busy_after_accept", 64'(o_ready), 64'd0);
        n = 1;
        while (!o_valid && n < 40) begin step(); n++; end
        check("latency", 64'(n), 64'(LAT));
        check("pos", 64'(o_pos), 64'(ep));
        check("lz", 64'(o_lz), 64'(el));
        check("zero", 64'(o_zero), 64'(ez));
        check("tag", 64'(o_tag), 64'(t));
        for (int s = 0; s < stall; s++) begin
            step();
            check("stall_hold", 64'({o_valid, o_ready, o_pos, o_lz, o_zero}),
                  64'({1'b1, 1'b0, ep, el, ez}));
        end
        i_ready = 1'b1;
        step();
        check("ready_after_result", 64'({o_valid, o_ready}), 64'b01);
    endtask

    typedef struct {
        logic [63:0]      d;
        logic [TAG_W-1:0] t;
        logic [5:0]       pos;
        logic [6:0]       lz;
        logic             z;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [63:0] rd, a_d, b_d;
        logic [5:0]  sp;
        logic [6:0]  sl;
        logic [TAG_W-1:0] st;
        logic [34:0] snap;
        int n, rp;

        vecs[0] = '{64'h8000_0000_0000_0000, 8'h5A, 6'd63, 7'd0,  1'b0};
        vecs[1] = '{64'h0000_0001_FFFF_FFFF, 8'h11, 6'd32, 7'd31, 1'b0};
        vecs[2] = '{64'h0000_0000_0001_0000, 8'h22, 6'd16, 7'd47, 1'b0};
        vecs[3] = '{64'h0000_0000_0000_0000, 8'h33, 6'd0,  7'd64, 1'b1};
        vecs[4] = '{64'h0000_0000_0000_0001, 8'h44, 6'd0,  7'd63, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hC3, 6'd63, 7'd0,  1'b0};

        i_rst = 1'b1; i_aclken = 1'b1; i_valid = 1'b0; i_data = 64'h0;
        i_tag = '0; i_ready = 1'b1;
        step(); step();
        check("reset_outputs", 64'({o_ready, o_valid, o_pos, o_lz, o_zero, o_tag, o_det_data}),
              64'({1'b1, 1'b0, 6'd0, 7'd0, 1'b0, 8'd0, 16'd0}));
        i_rst = 1'b0;
        step();

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].d, vecs[v].t, 0, vecs[v].pos, vecs[v].lz, vecs[v].z);

        // Randomized operands with random stalls
        for (int r = 0; r < 30; r++) begin
            rd = {$urandom, $urandom};
            rd = rd >> $urandom_range(0, 64);
            rp = ref_pos(rd);
            if (rp < 0) begin sp = 6'd0; sl = 7'd64; end
            else begin sp = 6'(rp); sl = 7'(63 - rp); end
            run_op(rd, TAG_W'($urandom), int'($urandom_range(0, 2)), sp, sl, rp < 0);
        end

        // i_ready low 5 cycles with i_valid held high; next operand taken right after release
        a_d = 64'h0000_0040_0000_0000;
        b_d = 64'h0000_0000_0000_8000;
        i_ready = 1'b0; i_valid = 1'b1; i_data = a_d; i_tag = 8'hA1;
        step();
        i_data = b_d; i_tag = 8'hB2;
        n = 1;
        while (!o_valid && n < 40) begin step(); n++; end
        check("hold_latency", 64'(n), 64'(LAT));
        check("hold_pos", 64'({o_pos, o_lz, o_tag}), 64'({6'd38, 7'd25, 8'hA1}));
        for (int s = 0; s < 5; s++) begin
            step();
            check("hold_stable", 64'({o_valid, o_ready, o_pos, o_lz, o_tag}),
                  64'({1'b1, 1'b0, 6'd38, 7'd25, 8'hA1}));
        end
        i_ready = 1'b1;
        step();
        check("hold_release", 64'({o_valid, o_ready}), 64'b01);
        step();
        i_valid = 1'b0;
        check("hold_next_accepted", 64'({o_valid, o_ready}), 64'b00);
        n = 1;
        while (!o_valid && n < 40) begin step(); n++; end
        check("hold_next_latency", 64'(n), 64'(LAT));
        check("hold_next_result", 64'({o_pos, o_lz, o_zero, o_tag}),
              64'({6'd15, 7'd48, 1'b0, 8'hB2}));
        step();
        check("hold_single_result", 64'({o_valid, o_ready}), 64'b01);

        // Clock enable toggling every cycle
        i_valid = 1'b1; i_data = 64'h3; i_tag = 8'h77;
        step();
        i_valid = 1'b0;
        n = 1;
        while (!o_valid && n < 40) begin
            i_aclken = 1'b0;
            snap = {o_valid, o_ready, o_det_data, o_pos, o_lz, o_zero, o_zero, o_zero};
            step();
            check("aclken_hold", 64'({o_valid, o_ready, o_det_data, o_pos, o_lz, o_zero, o_zero, o_zero}),
                  64'(snap));
            i_aclken = 1'b1;
            step();
            n++;
        end
        check("aclken_latency", 64'(n), 64'(LAT));
        check("aclken_result", 64'({o_pos, o_lz, o_zero, o_tag}),
              64'({6'd1, 7'd62, 1'b0, 8'h77}));
        step();

        // Reset during issue of slice 2 leaves no stale result
        i_valid = 1'b1; i_data = 64'hFFFF_FFFF_FFFF_FFFF; i_tag = 8'hEE;
        step();
        i_valid = 1'b0;
        step(); step();
        i_rst = 1'b1;
        #1;
        check("midop_reset", 64'({o_ready, o_valid, o_pos, o_lz, o_zero, o_tag, o_det_data}),
              64'({1'b1, 1'b0, 6'd0, 7'd0, 1'b0, 8'd0, 16'd0}));
        step();
        i_rst = 1'b0;
        run_op(64'h0400_0000_0000_0000, 8'h3C, 0, 6'd58, 7'd5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
